execute_stage: RTL and testbench

- EX stage of the 5-stage RISC-V pipeline; consumes the ID/EX control/data buffer outputs.
- Forwards operands from MEM/WB, runs the ALU, resolves branches/jumps and issues the fetch redirect.
- Contains the EX/MEM pipeline register with stall hold and bubble insertion, plus a taken-redirect counter.

---
 rtl/execute_stage_if.sv | 57 +++++
 rtl/execute_stage.sv | 149 ++++++++++++++
 tb/tb_execute_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Bundle of the ID/EX inputs, WB forwarding inputs, fetch redirect outputs and EX/MEM register
// outputs seen by the execute stage.
interface execute_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   logic             validE;
   logic [3:0]       aluopE;
   logic             rf_enE;
   logic             imm_enE;
   logic             jump_enE;
   logic [2:0]       br_typeE;
   logic             mem_readE;
   logic             mem_writeE;
   logic [1:0]       wb_selE;
   logic             sel_AE;
   logic [XLEN-1:0]  pcE;
   logic [XLEN-1:0]  rs1_dataE;
   logic [XLEN-1:0]  rs2_dataE;
   logic [XLEN-1:0]  immE;
   logic [4:0]       rs1E;
   logic [4:0]       rs2E;
   logic [4:0]       rdE;
   logic [XLEN-1:0]  wb_dataW;
   logic [4:0]       rdW;
   logic             rf_enW;
   logic             stall;

   logic             redirect;
   logic [XLEN-1:0]  redirect_pc;
   logic [XLEN-1:0]  alu_resultM;
   logic [XLEN-1:0]  write_dataM;
   logic [XLEN-1:0]  pc4M;
   logic [4:0]       rdM;
   logic             rf_enM;
   logic             mem_readM;
   logic             mem_writeM;
   logic             validM;
   logic [1:0]       wb_selM;
   logic [CNT_W-1:0] redirect_count;

   modport master (
      output validE, aluopE, rf_enE, imm_enE, jump_enE, br_typeE, mem_readE, mem_writeE,
             wb_selE, sel_AE, pcE, rs1_dataE, rs2_dataE, immE, rs1E, rs2E, rdE,
             wb_dataW, rdW, rf_enW, stall,
      input  redirect, redirect_pc, alu_resultM, write_dataM, pc4M, rdM, rf_enM,
             mem_readM, mem_writeM, validM, wb_selM, redirect_count
   );

   modport slave (
      input  validE, aluopE, rf_enE, imm_enE, jump_enE, br_typeE, mem_readE, mem_writeE,
             wb_selE, sel_AE, pcE, rs1_dataE, rs2_dataE, immE, rs1E, rs2E, rdE,
             wb_dataW, rdW, rf_enW, stall,
      output redirect, redirect_pc, alu_resultM, write_dataM, pc4M, rdM, rf_enM,
             mem_readM, mem_writeM, validM, wb_selM, redirect_count
   );
endinterface

// File: rtl/execute_stage.sv
// RISC-V EX stage: operand forwarding, ALU, branch/jump resolution with fetch redirect,
// EX/MEM pipeline register and a count of taken redirects.
module execute_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input logic            clk,
   input logic            rst,
   execute_stage_if.slave ex_bus
);
   logic [XLEN-1:0]  r_alu_result;
   logic [XLEN-1:0]  r_write_data;
   logic [XLEN-1:0]  r_pc4;
   logic [4:0]       r_rd;
   logic             r_rf_en;
   logic             r_mem_read;
   logic             r_mem_write;
   logic             r_valid;
   logic [1:0]       r_wb_sel;
   logic [CNT_W-1:0] r_count;

   logic [XLEN-1:0]  w_fwd1;
   logic [XLEN-1:0]  w_fwd2;
   logic [XLEN-1:0]  w_op_a;
   logic [XLEN-1:0]  w_op_b;
   logic [4:0]       w_shamt;
   logic [XLEN-1:0]  w_alu;
   logic             w_taken;
   logic             w_redirect;
   logic [XLEN-1:0]  w_redirect_pc;

   // Loads sitting in MEM have no data yet, so they are excluded from forwarding.
   logic w_mem_fwd_ok;
   assign w_mem_fwd_ok = r_valid & r_rf_en & (r_rd != 5'd0) & (r_wb_sel != 2'd1);

   always_comb begin
      w_fwd1 = ex_bus.rs1_dataE;
      if (w_mem_fwd_ok && (r_rd == ex_bus.rs1E)) begin
         w_fwd1 = r_alu_result;
      end else if (ex_bus.rf_enW && (ex_bus.rdW != 5'd0) && (ex_bus.rdW == ex_bus.rs1E)) begin
         w_fwd1 = ex_bus.wb_dataW;
      end
   end

   always_comb begin
      w_fwd2 = ex_bus.rs2_dataE;
      if (w_mem_fwd_ok && (r_rd == ex_bus.rs2E)) begin
         w_fwd2 = r_alu_result;
      end else if (ex_bus.rf_enW && (ex_bus.rdW != 5'd0) && (ex_bus.rdW == ex_bus.rs2E)) begin
         w_fwd2 = ex_bus.wb_dataW;
      end
   end

   assign w_op_a  = ex_bus.sel_AE  ? ex_bus.pcE  : w_fwd1;
   assign w_op_b  = ex_bus.imm_enE ? ex_bus.immE : w_fwd2;
   assign w_shamt = w_op_b[4:0];

   always_comb begin
      w_alu = '0;
      case (ex_bus.aluopE)
         4'd0:    w_alu = w_op_a + w_op_b;
         4'd1:    w_alu = w_op_a - w_op_b;
         4'd2:    w_alu = w_op_a << w_shamt;
         4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
         4'd4:    w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
         4'd5:    w_alu = w_op_a ^ w_op_b;
         4'd6:    w_alu = w_op_a >> w_shamt;
         4'd7:    w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
         4'd8:    w_alu = w_op_a | w_op_b;
         4'd9:    w_alu = w_op_a & w_op_b;
         4'd10:   w_alu = w_op_b;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (ex_bus.br_typeE)
         3'd1:    w_taken = (w_fwd1 == w_fwd2);
         3'd2:    w_taken = (w_fwd1 != w_fwd2);
         3'd4:    w_taken = ($signed(w_fwd1) <  $signed(w_fwd2));
         3'd5:    w_taken = ($signed(w_fwd1) >= $signed(w_fwd2));
         3'd6:    w_taken = (w_fwd1 <  w_fwd2);
         3'd7:    w_taken = (w_fwd1 >= w_fwd2);
         default: w_taken = 1'b0;
      endcase
   end

   assign w_redirect    = ex_bus.validE & ~ex_bus.stall & (ex_bus.jump_enE | w_taken);
   assign w_redirect_pc = ex_bus.jump_enE ? {w_alu[XLEN-1:1], 1'b0}
                                          : (ex_bus.pcE + ex_bus.immE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alu_result <= '0;
         r_write_data <= '0;
         r_pc4        <= '0;
         r_rd         <= '0;
         r_rf_en      <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_valid      <= 1'b0;
         r_wb_sel     <= '0;
      end else if (!ex_bus.stall) begin
         if (ex_bus.validE) begin
            r_alu_result <= w_alu;
            r_write_data <= w_fwd2;
            r_pc4        <= ex_bus.pcE + XLEN'(4);
            r_rd         <= ex_bus.rdE;
            r_rf_en      <= ex_bus.rf_enE;
            r_mem_read   <= ex_bus.mem_readE;
            r_mem_write  <= ex_bus.mem_writeE;
            r_valid      <= 1'b1;
            r_wb_sel     <= ex_bus.wb_selE;
         end else begin
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc4        <= '0;
            r_rd         <= '0;
            r_rf_en      <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_valid      <= 1'b0;
            r_wb_sel     <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_redirect) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign ex_bus.redirect       = w_redirect;
   assign ex_bus.redirect_pc    = w_redirect_pc;
   assign ex_bus.alu_resultM    = r_alu_result;
   assign ex_bus.write_dataM    = r_write_data;
   assign ex_bus.pc4M           = r_pc4;
   assign ex_bus.rdM            = r_rd;
   assign ex_bus.rf_enM         = r_rf_en;
   assign ex_bus.mem_readM      = r_mem_read;
   assign ex_bus.mem_writeM     = r_mem_write;
   assign ex_bus.validM         = r_valid;
   assign ex_bus.wb_selM        = r_wb_sel;
   assign ex_bus.redirect_count = r_count;
endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: forwarding, ALU ops, branches, JALR, stall and reset.
module tb_execute_stage;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   execute_stage_if #(.XLEN(32), .CNT_W(32)) ex_bus ();

   execute_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .ex_bus (ex_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ex_bus.validE     = 1'b0;
      ex_bus.aluopE     = 4'd0;
      ex_bus.rf_enE     = 1'b0;
      ex_bus.imm_enE    = 1'b0;
      ex_bus.jump_enE   = 1'b0;
      ex_bus.br_typeE   = 3'd0;
      ex_bus.mem_readE  = 1'b0;
      ex_bus.mem_writeE = 1'b0;
      ex_bus.wb_selE    = 2'd0;
      ex_bus.sel_AE     = 1'b0;
      ex_bus.pcE        = '0;
      ex_bus.rs1_dataE  = '0;
      ex_bus.rs2_dataE  = '0;
      ex_bus.immE       = '0;
      ex_bus.rs1E       = 5'd0;
      ex_bus.rs2E       = 5'd0;
      ex_bus.rdE        = 5'd0;
      ex_bus.wb_dataW   = '0;
      ex_bus.rdW        = 5'd0;
      ex_bus.rf_enW     = 1'b0;
      ex_bus.stall      = 1'b0;
   endtask

   logic [3:0]  alu_op  [11];
   logic [31:0] alu_a   [11];
   logic [31:0] alu_b   [11];
   logic [31:0] alu_exp [11];

   initial begin
      n_cmp = 0;
      n_err = 0;
      alu_op = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};
      alu_a  = '{32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h8000_0000,
                 32'h8000_0000, 32'hF0, 32'hF0, 32'h1, 32'd5};
      alu_b  = '{32'd7, 32'h24, 32'd1, 32'd1, 32'hFF00_FF00, 32'd4, 32'd4, 32'h0F, 32'h3C,
                 32'h1234_5000, 32'd7};
      alu_exp = '{32'hFFFF_FFFE, 32'h10, 32'd1, 32'd0, 32'h0FF0_0FF0, 32'h0800_0000,
                  32'hF800_0000, 32'hFF, 32'h30, 32'h1234_5000, 32'd0};

      rst = 1'b0;
      clear_inputs();
      #3;
      check_eq("reset validM", {31'd0, ex_bus.validM}, 32'd0);
      check_eq("reset alu_resultM", ex_bus.alu_resultM, 32'd0);
      check_eq("reset redirect_count", ex_bus.redirect_count, 32'd0);
      step();
      rst = 1'b1;
      step();

      // ADD x3 = x1 + x2
      ex_bus.validE = 1'b1; ex_bus.rf_enE = 1'b1;
      ex_bus.rs1E = 5'd1; ex_bus.rs2E = 5'd2; ex_bus.rdE = 5'd3;
      ex_bus.rs1_dataE = 32'd5; ex_bus.rs2_dataE = 32'd7;
      step();
      check_eq("add alu_resultM", ex_bus.alu_resultM, 32'd12);
      check_eq("add rdM", {27'd0, ex_bus.rdM}, 32'd3);
      check_eq("add rf_enM", {31'd0, ex_bus.rf_enM}, 32'd1);
      check_eq("add validM", {31'd0, ex_bus.validM}, 32'd1);

      // MEM forward beats WB forward
      ex_bus.rs1E = 5'd3; ex_bus.rs1_dataE = 32'd0;
      ex_bus.rs2E = 5'd4; ex_bus.rs2_dataE = 32'd1; ex_bus.rdE = 5'd5;
      ex_bus.rdW = 5'd3; ex_bus.rf_enW = 1'b1; ex_bus.wb_dataW = 32'd99;
      step();
      check_eq("fwd mem priority", ex_bus.alu_resultM, 32'd13);

      // WB-only forward; rdE=0 with rf_enE passed through
      ex_bus.rdE = 5'd0;
      step();
      check_eq("fwd wb", ex_bus.alu_resultM, 32'd100);
      check_eq("rd0 rdM", {27'd0, ex_bus.rdM}, 32'd0);
      check_eq("rd0 rf_enM", {31'd0, ex_bus.rf_enM}, 32'd1);

      // x0 never forwarded from MEM or WB
      ex_bus.rs1E = 5'd0; ex_bus.rs1_dataE = 32'd7; ex_bus.rdW = 5'd0; ex_bus.rdE = 5'd6;
      step();
      check_eq("no fwd x0", ex_bus.alu_resultM, 32'd8);

      // Store: rs2 forwarded from MEM into write_dataM, B = imm
      ex_bus.rf_enW = 1'b0; ex_bus.rf_enE = 1'b0; ex_bus.mem_writeE = 1'b1;
      ex_bus.imm_enE = 1'b1; ex_bus.immE = 32'h10;
      ex_bus.rs1E = 5'd7; ex_bus.rs1_dataE = 32'h1000;
      ex_bus.rs2E = 5'd6; ex_bus.rs2_dataE = 32'd0; ex_bus.rdE = 5'd0;
      step();
      check_eq("store addr", ex_bus.alu_resultM, 32'h1010);
      check_eq("store fwd rs2", ex_bus.write_dataM, 32'd8);
      check_eq("store mem_writeM", {31'd0, ex_bus.mem_writeM}, 32'd1);

      // Load into x9, then a consumer must not see the load's address as data
      ex_bus.mem_writeE = 1'b0; ex_bus.mem_readE = 1'b1; ex_bus.rf_enE = 1'b1;
      ex_bus.wb_selE = 2'd1; ex_bus.immE = 32'd4; ex_bus.rs2E = 5'd0; ex_bus.rdE = 5'd9;
      step();
      check_eq("load addr", ex_bus.alu_resultM, 32'h1004);
      check_eq("load mem_readM", {31'd0, ex_bus.mem_readM}, 32'd1);
      ex_bus.mem_readE = 1'b0; ex_bus.wb_selE = 2'd0; ex_bus.imm_enE = 1'b0;
      ex_bus.rs1E = 5'd9; ex_bus.rs1_dataE = 32'h55; ex_bus.rdE = 5'd12;
      step();
      check_eq("no load fwd", ex_bus.alu_resultM, 32'h55);

      // ALU operation table
      ex_bus.rs1E = 5'd10; ex_bus.rs2E = 5'd11;
      for (int i = 0; i < 11; i++) begin
         ex_bus.aluopE = alu_op[i];
         ex_bus.rs1_dataE = alu_a[i];
         ex_bus.rs2_dataE = alu_b[i];
         step();
         check_eq($sformatf("alu op %0d", alu_op[i]), ex_bus.alu_resultM, alu_exp[i]);
      end

      // BLT taken (signed), BLTU not taken
      ex_bus.aluopE = 4'd0; ex_bus.rf_enE = 1'b0; ex_bus.br_typeE = 3'd4;
      ex_bus.rs1_dataE = 32'hFFFF_FFFF; ex_bus.rs2_dataE = 32'd1;
      ex_bus.pcE = 32'h100; ex_bus.immE = 32'h20;
      #1;
      check_eq("blt redirect", {31'd0, ex_bus.redirect}, 32'd1);
      check_eq("blt redirect_pc", ex_bus.redirect_pc, 32'h120);
      step();
      check_eq("blt count", ex_bus.redirect_count, 32'd1);
      ex_bus.br_typeE = 3'd6;
      #1;
      check_eq("bltu redirect", {31'd0, ex_bus.redirect}, 32'd0);
      step();
      check_eq("bltu count", ex_bus.redirect_count, 32'd1);

      // JALR x1, 4(x10)
      ex_bus.br_typeE = 3'd0; ex_bus.jump_enE = 1'b1; ex_bus.imm_enE = 1'b1;
      ex_bus.immE = 32'd4; ex_bus.rs1_dataE = 32'h203; ex_bus.wb_selE = 2'd2;
      ex_bus.rf_enE = 1'b1; ex_bus.rdE = 5'd1; ex_bus.pcE = 32'h40;
      #1;
      check_eq("jalr redirect_pc", ex_bus.redirect_pc, 32'h206);
      step();
      check_eq("jalr pc4M", ex_bus.pc4M, 32'h44);
      check_eq("jalr alu_resultM", ex_bus.alu_resultM, 32'h207);
      check_eq("jalr count", ex_bus.redirect_count, 32'd2);

      // Stall with a new jump waiting: everything holds
      ex_bus.stall = 1'b1; ex_bus.pcE = 32'h80; ex_bus.rs1_dataE = 32'h301;
      #1;
      check_eq("stall redirect", {31'd0, ex_bus.redirect}, 32'd0);
      step();
      step();
      step();
      check_eq("stall alu hold", ex_bus.alu_resultM, 32'h207);
      check_eq("stall pc4 hold", ex_bus.pc4M, 32'h44);
      check_eq("stall count hold", ex_bus.redirect_count, 32'd2);
      ex_bus.stall = 1'b0;
      #1;
      check_eq("unstall redirect_pc", ex_bus.redirect_pc, 32'h304);
      step();
      check_eq("unstall pc4M", ex_bus.pc4M, 32'h84);
      check_eq("unstall count", ex_bus.redirect_count, 32'd3);

      // Bubble
      ex_bus.validE = 1'b0;
      step();
      check_eq("bubble validM", {31'd0, ex_bus.validM}, 32'd0);
      check_eq("bubble rf_enM", {31'd0, ex_bus.rf_enM}, 32'd0);

      // Async reset in the middle of a stall with a valid EX/MEM entry
      ex_bus.validE = 1'b1;
      step();
      check_eq("pre-reset validM", {31'd0, ex_bus.validM}, 32'd1);
      ex_bus.stall = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_eq("async rst validM", {31'd0, ex_bus.validM}, 32'd0);
      check_eq("async rst alu", ex_bus.alu_resultM, 32'd0);
      check_eq("async rst count", ex_bus.redirect_count, 32'd0);
      rst = 1'b1;
      ex_bus.stall = 1'b0;
      ex_bus.validE = 1'b0;
      step();
      check_eq("post-rst bubble validM", {31'd0, ex_bus.validM}, 32'd0);
      check_eq("post-rst count", ex_bus.redirect_count, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
